// File: rtl/fp_div_seq.sv
// Sequential IEEE-754 single-precision divider.
// Radix-2 restoring mantissa datapath, one quotient bit per cycle, RNE rounding.
// Fixed 28-cycle latency from the start edge to done for every operand class.
module fp_div_seq #(
  parameter int unsigned MANT_W = 23,
  parameter int unsigned EXP_W  = 8,
  parameter int unsigned BIAS   = 127,
  parameter int unsigned ITER   = 26
) (
  input  logic                      fp_clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [EXP_W+MANT_W:0]     A,
  input  logic [EXP_W+MANT_W:0]     B,
  output logic [EXP_W+MANT_W:0]     Out,
  output logic                      done,
  output logic                      busy
);

  localparam int unsigned FP_W  = 1 + EXP_W + MANT_W;
  localparam int unsigned SIG_W = MANT_W + 1;          // significand with hidden bit
  localparam int unsigned REM_W = SIG_W + 1;           // restoring remainder
  localparam int unsigned E_W   = EXP_W + 2;           // signed working exponent
  localparam int unsigned CNT_W = $clog2(ITER);

  localparam logic [EXP_W-1:0]        EXP_MAX  = '1;
  localparam logic [CNT_W-1:0]        CNT_LAST = CNT_W'(ITER - 1);
  localparam logic signed [E_W-1:0]   E_INF    = E_W'((1 << EXP_W) - 1);
  localparam logic signed [E_W-1:0]   E_ZERO   = '0;
  localparam logic [FP_W-1:0]         QNAN     = {1'b0, EXP_MAX, 1'b1, (MANT_W-1)'(0)};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DIV   = 2'd1,
    ROUND = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t                   state;
  logic [CNT_W-1:0]         cnt;
  logic                     sign;
  logic signed [E_W-1:0]    exp_r;
  logic [SIG_W-1:0]         m_b;
  logic [REM_W-1:0]         rem;
  logic [ITER-1:0]          quo;
  logic                     a_zero, b_zero, a_inf, b_inf, any_nan;
  logic [FP_W-1:0]          res;

  // Operand field extraction and classification
  logic [EXP_W-1:0]  exp_a_c, exp_b_c;
  logic [MANT_W-1:0] frac_a_c, frac_b_c;
  logic              a_zero_c, b_zero_c, a_inf_c, b_inf_c, a_nan_c, b_nan_c;

  // Operand classification; exponent 0 (zero or denormal) flushes to zero
  always_comb begin
    exp_a_c  = A[FP_W-2 -: EXP_W];
    exp_b_c  = B[FP_W-2 -: EXP_W];
    frac_a_c = A[MANT_W-1:0];
    frac_b_c = B[MANT_W-1:0];
    a_zero_c = (exp_a_c == '0);
    b_zero_c = (exp_b_c == '0);
    a_inf_c  = (exp_a_c == EXP_MAX) && (frac_a_c == '0);
    b_inf_c  = (exp_b_c == EXP_MAX) && (frac_b_c == '0);
    a_nan_c  = (exp_a_c == EXP_MAX) && (frac_a_c != '0);
    b_nan_c  = (exp_b_c == EXP_MAX) && (frac_b_c != '0);
  end

  // One restoring step: trial subtract, keep on non-negative result
  logic [REM_W-1:0] diff_c, rem_sel_c;
  logic             ge_c;

  // Restoring division step
  always_comb begin
    ge_c      = (rem >= {1'b0, m_b});
    diff_c    = rem - {1'b0, m_b};
    rem_sel_c = ge_c ? diff_c : rem;
  end

  // Normalisation, rounding, exponent limits and special-case selection
  logic                  norm_c, guard_c, sticky_c, rnd_up_c;
  logic [SIG_W-1:0]      sig_c;
  logic [SIG_W:0]        sum_c;
  logic [MANT_W-1:0]     frac_c;
  logic signed [E_W-1:0] e_c;
  logic [FP_W-1:0]       res_c;

  // Result assembly from quotient, remainder and operand classes
  always_comb begin
    norm_c   = quo[ITER-1];
    sig_c    = '0;
    guard_c  = 1'b0;
    sticky_c = 1'b0;
    e_c      = exp_r;
    sum_c    = '0;
    frac_c   = '0;
    res_c    = '0;

    if (norm_c) begin
      sig_c    = quo[ITER-1:2];
      guard_c  = quo[1];
      sticky_c = quo[0] | (|rem);
    end else begin
      // Ratio below one: one more quotient bit becomes significant
      sig_c    = quo[ITER-2:1];
      guard_c  = quo[0];
      sticky_c = |rem;
      e_c      = exp_r - E_W'(1);
    end

    rnd_up_c = guard_c & (sticky_c | sig_c[0]);
    sum_c    = {1'b0, sig_c} + (SIG_W+1)'(rnd_up_c);

    if (sum_c[SIG_W]) begin
      // Rounding carried out of the significand: renormalise
      frac_c = sum_c[MANT_W:1];
      e_c    = e_c + E_W'(1);
    end else begin
      frac_c = sum_c[MANT_W-1:0];
    end

    if (e_c >= E_INF) begin
      res_c = {sign, EXP_MAX, MANT_W'(0)};
    end else if (e_c <= E_ZERO) begin
      res_c = {sign, (FP_W-1)'(0)};
    end else begin
      res_c = {sign, e_c[EXP_W-1:0], frac_c};
    end

    if (any_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
      res_c = QNAN;
    end else if (a_inf || b_zero) begin
      res_c = {sign, EXP_MAX, MANT_W'(0)};
    end else if (b_inf || a_zero) begin
      res_c = {sign, (FP_W-1)'(0)};
    end
  end

  // Control FSM with datapath registers and registered outputs
  always_ff @(posedge fp_clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      sign    <= 1'b0;
      exp_r   <= '0;
      m_b     <= '0;
      rem     <= '0;
      quo     <= '0;
      a_zero  <= 1'b0;
      b_zero  <= 1'b0;
      a_inf   <= 1'b0;
      b_inf   <= 1'b0;
      any_nan <= 1'b0;
      res     <= '0;
      Out     <= '0;
      done    <= 1'b0;
      busy    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            sign    <= A[FP_W-1] ^ B[FP_W-1];
            exp_r   <= E_W'(exp_a_c) - E_W'(exp_b_c) + E_W'(BIAS);
            m_b     <= {~b_zero_c, frac_b_c};
            rem     <= {1'b0, ~a_zero_c, frac_a_c};
            quo     <= '0;
            a_zero  <= a_zero_c;
            b_zero  <= b_zero_c;
            a_inf   <= a_inf_c;
            b_inf   <= b_inf_c;
            any_nan <= a_nan_c | b_nan_c;
            cnt     <= '0;
            busy    <= 1'b1;
            state   <= DIV;
          end
        end

        DIV: begin
          // Partial remainder stays below 2*m_b, so the shift loses nothing
          rem <= {rem_sel_c[REM_W-2:0], 1'b0};
          quo <= {quo[ITER-2:0], ge_c};
          cnt <= cnt + 1'b1;
          if (cnt == CNT_LAST) begin
            state <= ROUND;
          end
        end

        ROUND: begin
          res   <= res_c;
          state <= DONE;
        end

        DONE: begin
          // First DONE cycle publishes the result; second retires to IDLE
          if (!done) begin
            Out  <= res;
            done <= 1'b1;
          end else begin
            done  <= 1'b0;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fp_div_seq.sv
// Directed testbench for fp_div_seq: latency, rounding, specials, limits, handshake, reset.
module tb_fp_div_seq;

  logic        fp_clk;
  logic        rst_n;
  logic        start;
  logic [31:0] A;
  logic [31:0] B;
  logic [31:0] Out;
  logic        done;
  logic        busy;

  int errors = 0;
  int checks = 0;

  fp_div_seq dut (
    .fp_clk (fp_clk),
    .rst_n  (rst_n),
    .start  (start),
    .A      (A),
    .B      (B),
    .Out    (Out),
    .done   (done),
    .busy   (busy)
  );

  initial fp_clk = 1'b0;
  always #5 fp_clk = ~fp_clk;

  // Single comparison point for every check
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Present operands with start for one edge, then scramble the inputs
  task automatic issue(input logic [31:0] a, input logic [31:0] b);
    @(negedge fp_clk);
    A     = a;
    B     = b;
    start = 1'b1;
    @(posedge fp_clk);
    #1;
    start = 1'b0;
    A     = $urandom;
    B     = $urandom;
  endtask

  // Count edges after the start edge until done; 0 means it never came
  task automatic wait_done(output int lat);
    lat = 0;
    for (int k = 1; k <= 60; k++) begin
      @(posedge fp_clk);
      #1;
      if (done) begin
        lat = k;
        break;
      end
    end
  endtask

  // Full operation: latency, result, single-cycle done, busy release
  task automatic run(input string tag, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] exp);
    int lat;
    issue(a, b);
    wait_done(lat);
    check({tag, "_lat"}, lat, 28);
    check(tag, Out, exp);
    check({tag, "_busy_in_done"}, {31'd0, busy}, 32'd1);
    @(posedge fp_clk);
    #1;
    check({tag, "_done_low"}, {31'd0, done}, 32'd0);
    check({tag, "_busy_low"}, {31'd0, busy}, 32'd0);
    check({tag, "_out_hold"}, Out, exp);
  endtask

  initial begin
    int ndone;
    int first_k;
    int lat;
    logic [31:0] first_out;

    rst_n = 1'b0;
    start = 1'b0;
    A     = '0;
    B     = '0;

    // Reset state
    repeat (2) @(posedge fp_clk);
    #1;
    check("rst_out", Out, 32'h0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    rst_n = 1'b1;

    // Basic quotient and rounding
    run("div_4_2",     32'h40800000, 32'h40000000, 32'h40000000);
    run("div_1_3",     32'h3F800000, 32'h40400000, 32'h3EAAAAAB);
    run("div_1e4_100", 32'h461C4000, 32'h42C80000, 32'h42C80000);
    run("div_m6_2",    32'hC0C00000, 32'h40000000, 32'hC0400000);

    // Special operands
    run("x_div_0",     32'h3F800000, 32'h00000000, 32'h7F800000);
    run("zero_zero",   32'h00000000, 32'h00000000, 32'h7FC00000);
    run("inf_inf",     32'h7F800000, 32'h7F800000, 32'h7FC00000);
    run("m1_div_inf",  32'hBF800000, 32'h7F800000, 32'h80000000);
    run("nan_a",       32'h7FC00001, 32'h3F800000, 32'h7FC00000);
    run("inf_div_2",   32'h7F800000, 32'h40000000, 32'h7F800000);
    run("zero_div_5",  32'h00000000, 32'h40A00000, 32'h00000000);

    // Exponent limits and denormal flush
    run("overflow",    32'h7F000000, 32'h3E800000, 32'h7F800000);
    run("underflow",   32'h00800000, 32'h40000000, 32'h00000000);
    run("denorm_a",    32'h00000001, 32'h3F800000, 32'h00000000);

    // Start while busy (mid-divide and in the done cycle) is ignored
    issue(32'h40800000, 32'h40000000);
    ndone     = 0;
    first_k   = 0;
    first_out = '0;
    for (int k = 1; k <= 70; k++) begin
      @(posedge fp_clk);
      #1;
      start = 1'b0;
      if (done) begin
        ndone++;
        if (ndone == 1) begin
          first_k   = k;
          first_out = Out;
        end
      end
      if (k == 5 || k == 28) begin
        start = 1'b1;
        A     = 32'h3F800000;
        B     = 32'h40400000;
      end
    end
    check("ign_ndone", ndone, 1);
    check("ign_lat", first_k, 28);
    check("ign_out", first_out, 32'h40000000);
    check("ign_busy", {31'd0, busy}, 32'd0);

    // Back-to-back: second issue in the cycle right after done
    run("b2b_first",   32'hC0C00000, 32'h40000000, 32'hC0400000);
    run("b2b_second",  32'h3F800000, 32'h40400000, 32'h3EAAAAAB);

    // Reset mid-operation aborts without a done pulse
    issue(32'h40800000, 32'h40000000);
    repeat (10) @(posedge fp_clk);
    #1;
    rst_n = 1'b0;
    @(posedge fp_clk);
    #1;
    rst_n = 1'b1;
    check("mid_rst_out", Out, 32'h0);
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    ndone = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge fp_clk);
      #1;
      if (done) ndone++;
    end
    check("mid_rst_ndone", ndone, 0);
    check("mid_rst_idle_out", Out, 32'h0);
    issue(32'h40800000, 32'h40000000);
    wait_done(lat);
    check("post_rst_lat", lat, 28);
    check("post_rst_out", Out, 32'h40000000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
